// File: rtl/instr_encoder_if.sv
// Valid/ready field-bundle input and encoded-word output of the instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RISC-V fields into a 32-bit word through a one-stage valid/ready register,
// substituting a NOP for bundles whose immediate or opcode is unencodable.
module instr_encoder #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [31:0] ERR_NOP = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  instr_encoder_if.slave    bus,
  output logic [CNT_W-1:0]  acc_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic              out_valid_q;
  logic [31:0]       out_instr_q, instr_d;
  logic              out_err_q, err_d;
  logic [CNT_W-1:0]  acc_q, err_q;
  logic              accept;
  logic              fits_12, fits_13, fits_21;
  logic [31:0]       imm;

  assign imm          = bus.in_imm;
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Sign-extension check: upper bits must be all copies of the field's sign bit
  assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    instr_d = ERR_NOP;
    err_d   = 1'b1;
    case (bus.in_opcode)
      OP_R_TYPE: begin
        instr_d = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        err_d   = 1'b0;
      end
      OP_I_TYPE, OP_LOAD: begin
        if (fits_12) begin
          instr_d = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
          err_d   = 1'b0;
        end
      end
      OP_STORE: begin
        if (fits_12) begin
          instr_d = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
          err_d   = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (fits_13 && !imm[0]) begin
          instr_d = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     imm[4:1], imm[11], bus.in_opcode};
          err_d   = 1'b0;
        end
      end
      OP_JAL: begin
        if (fits_21 && !imm[0]) begin
          instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
          err_d   = 1'b0;
        end
      end
      default: begin
        instr_d = ERR_NOP;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      acc_q       <= '0;
      err_q       <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_instr_q <= instr_d;
        out_err_q   <= err_d;
        if (acc_q != '1) acc_q <= acc_q + CNT_W'(1);
        if (err_d && (err_q != '1)) err_q <= err_q + CNT_W'(1);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign acc_count     = acc_q;
  assign err_count     = err_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Packs decoded RISC-V instruction fields (opcode, register indices, funct3/funct7, 32-bit immediate) back into a 32-bit instruction word. It performs the exact inverse of the core's immediate extraction for I/S/B/J formats and also handles R-type. It is used by the self-test instruction loader and the bench stimulus path to write instruction memory. It is a single-stage valid/ready pipeline with immediate range checking and saturating statistics counters.

Parameters:
CNT_W, 16, width of the accepted-instruction and error counters
ERR_NOP, 32'h00000013, word emitted in place of any instruction that fails checking (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
in_opcode  input  7  opcode; uses riscv_pkg constants OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R-type only)
in_imm  input  32  signed immediate, byte offset for B/J
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts word
out_instr  output  32  encoded instruction or ERR_NOP
out_err  output  1  qualifies out_instr: 1 = bundle rejected, ERR_NOP substituted
acc_count  output  CNT_W  bundles accepted since reset, saturating
err_count  output  CNT_W  bundles rejected since reset, saturating

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_err=0, acc_count=0, err_count=0. in_ready=1 once rst deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
  - Latency is 1 cycle: a bundle accepted in cycle N appears on out_instr in cycle N+1.
  - Full throughput while out_ready=1.
- Output register:
  - On acceptance: out_valid<=1 and out_instr/out_err are loaded.
  - On output transfer without a new acceptance: out_valid<=0 and out_instr/out_err hold their last value.
  - While out_valid && !out_ready: out_instr and out_err are stable, and in_ready=0.
  - Simultaneous transfer and acceptance: the new word replaces the old one and out_valid stays 1.
- Encoding (imm = in_imm):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I (OP_I_TYPE, OP_LOAD): {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Checks (any failure sets out_err=1 and out_instr=ERR_NOP):
  - I/S: imm must lie in [-2048, 2047], i.e. imm[31:11] all equal.
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-1048576, 1048574] and imm[0]=0.
  - R: imm is ignored and never causes an error.
  - Any opcode other than the six listed: error.
- Counters:
  - On every acceptance, acc_count increments; err_count also increments if the bundle is rejected.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - Counters update in the same edge that loads the output register.
- A reset asserted mid-stream discards the held word (out_valid=0) and clears the counters immediately, without waiting for a clock edge.

Test Plan:
- I-type: opcode=OP_I_TYPE, rd=1, rs1=0, funct3=0, imm=5 -> out_instr=0x00500093, out_err=0, one cycle after acceptance; acc_count=1.
- S and B: sw x2,8(x1) -> 0x0020A423. beq x1,x2,imm=-4 -> 0xFE208EE3. jal rd=1, imm=2048 -> 0x001000EF.
- Errors, one bundle at a time:
  - addi imm=2048 -> 0x00000013, out_err=1.
  - beq imm=6 encodes normally; beq imm=7 -> out_err=1.
  - opcode=7'h7F -> out_err=1.
  - After these four bundles, err_count=3 and acc_count=4.
- Backpressure: stream 3 bundles back-to-back with out_ready held 0 for 4 cycles after the first acceptance -> in_ready=0 and out_instr stable throughout; after release, all 3 words emerge in order with no loss or duplication.
- Saturation: with CNT_W=4, send 20 valid bundles -> acc_count sticks at 15 and err_count stays 0.
- Reset: assert rst asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 and both counters read 0 before the next clk edge; the first bundle after release encodes correctly.
